// File: rtl/ycbcr_rgb.sv
// Y/Cb/Cr (Q8.8, chroma biased) to packed 8-bit RGB; 3-stage pipeline with a global
// stall on downstream back-pressure, rounding half up and saturation to 0..255.
module ycbcr_rgb #(
  parameter int unsigned C_RCR      = 359,
  parameter int unsigned C_GCB      = 88,
  parameter int unsigned C_GCR      = 183,
  parameter int unsigned C_BCB      = 454,
  parameter int unsigned CHROMA_OFS = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] Y,
  input  logic [15:0] Cb,
  input  logic [15:0] Cr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data
);

  localparam int unsigned IN_W  = 16;
  localparam int unsigned CH_W  = 17;
  localparam int unsigned P_W   = 27;
  localparam int unsigned OUT_W = 24;

  localparam logic signed [P_W-1:0]  K_RCR    = P_W'(C_RCR);
  localparam logic signed [P_W-1:0]  K_GCB    = P_W'(C_GCB);
  localparam logic signed [P_W-1:0]  K_GCR    = P_W'(C_GCR);
  localparam logic signed [P_W-1:0]  K_BCB    = P_W'(C_BCB);
  localparam logic signed [CH_W-1:0] OFS      = CH_W'(CHROMA_OFS);
  localparam logic signed [P_W-1:0]  HALF     = P_W'(32768);
  localparam logic signed [P_W-1:0]  SAT_MAX  = P_W'(255);

  logic                   advance;

  logic                   v1_q, v1_d;
  logic [IN_W-1:0]        y1_q, y1_d;
  logic signed [CH_W-1:0] cb1_q, cb1_d, cr1_q, cr1_d;

  logic                   v2_q, v2_d;
  logic signed [P_W-1:0]  y2_q, y2_d, pr_q, pr_d, pgb_q, pgb_d, pgr_q, pgr_d, pb_q, pb_d;

  logic                   v3_q, v3_d;
  logic [OUT_W-1:0]       pix_q, pix_d;

  logic signed [P_W-1:0]  acc_r, acc_g, acc_b;

  // Q16 accumulator -> rounded, clamped 8-bit channel
  function automatic logic [7:0] round_sat(input logic signed [P_W-1:0] acc);
    logic signed [P_W-1:0] sh;
    sh = (acc + HALF) >>> 16;
    if (sh[P_W-1])        return 8'h00;
    else if (sh > SAT_MAX) return 8'hFF;
    else                   return sh[7:0];
  endfunction

  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign out_data  = pix_q;

  always_comb begin
    acc_r = y2_q + pr_q;
    acc_g = y2_q - pgb_q - pgr_q;
    acc_b = y2_q + pb_q;
  end

  // Next state: every stage holds unless the whole pipe advances
  always_comb begin
    v1_d  = v1_q;
    y1_d  = y1_q;
    cb1_d = cb1_q;
    cr1_d = cr1_q;
    v2_d  = v2_q;
    y2_d  = y2_q;
    pr_d  = pr_q;
    pgb_d = pgb_q;
    pgr_d = pgr_q;
    pb_d  = pb_q;
    v3_d  = v3_q;
    pix_d = pix_q;
    if (advance) begin
      v1_d  = in_valid;
      y1_d  = Y;
      cb1_d = $signed(CH_W'(Cb)) - OFS;
      cr1_d = $signed(CH_W'(Cr)) - OFS;

      v2_d  = v1_q;
      y2_d  = P_W'({y1_q, 8'h00});
      pr_d  = K_RCR * P_W'(cr1_q);
      pgb_d = K_GCB * P_W'(cb1_q);
      pgr_d = K_GCR * P_W'(cr1_q);
      pb_d  = K_BCB * P_W'(cb1_q);

      v3_d  = v2_q;
      pix_d = {round_sat(acc_r), round_sat(acc_g), round_sat(acc_b)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      y1_q  <= '0;
      cb1_q <= '0;
      cr1_q <= '0;
      v2_q  <= 1'b0;
      y2_q  <= '0;
      pr_q  <= '0;
      pgb_q <= '0;
      pgr_q <= '0;
      pb_q  <= '0;
      v3_q  <= 1'b0;
      pix_q <= '0;
    end else begin
      v1_q  <= v1_d;
      y1_q  <= y1_d;
      cb1_q <= cb1_d;
      cr1_q <= cr1_d;
      v2_q  <= v2_d;
      y2_q  <= y2_d;
      pr_q  <= pr_d;
      pgb_q <= pgb_d;
      pgr_q <= pgr_d;
      pb_q  <= pb_d;
      v3_q  <= v3_d;
      pix_q <= pix_d;
    end
  end

endmodule
